// File: rtl/sync_fifo_ext_pkg.sv
// Shared types and constants for the extended synchronous FIFO.
// Read-mode enum, default thresholds and the count-width helper.
package sync_fifo_pkg;

   typedef enum logic {
      FIFO_STD,
      FIFO_FWFT
   } fifo_mode_e;

   localparam int DEF_AEMPTY_THRESH = 4;
   localparam int DEF_AFULL_MARGIN  = 4;

   // Wide enough to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_ext_ptr_wrap.sv
// Modulo-DEPTH pointer with explicit wrap, so DEPTH need not be a power of two.
module fifo_ptr_wrap #(
   parameter int DEPTH = 32,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
      end
   end

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, full-range count, thresholds,
// overflow/underflow pulses and selectable standard or FWFT read mode.
module sync_fifo_ext
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 32,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = FIFO_DEPTH - DEF_AFULL_MARGIN,
   parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
   parameter int CNT_WIDTH     = cnt_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int         PTR_W = $clog2(FIFO_DEPTH);
   localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // A same-cycle read frees a slot at full; a same-cycle write never feeds an empty read.
   always_comb begin
      rd_acc = ren && !empty;
      wr_acc = wen && (!full || rd_acc);
   end

   assign empty        = (count == '0);
   assign full         = (count == CNT_WIDTH'(FIFO_DEPTH));
   assign almost_full  = (int'(count) >= AFULL_THRESH);
   assign almost_empty = (int'(count) <= AEMPTY_THRESH);

   fifo_ptr_wrap #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_acc),
      .ptr (wr_ptr)
   );

   fifo_ptr_wrap #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_acc),
      .ptr (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wen && !wr_acc;
         underflow <= ren && !rd_acc;
         if (wr_acc && !rd_acc) begin
            count <= count + CNT_WIDTH'(1);
         end else if (rd_acc && !wr_acc) begin
            count <= count - CNT_WIDTH'(1);
         end
      end
   end

   generate
      if (MODE == FIFO_FWFT) begin : g_fwft
         // Head is visible combinationally; forced to zero while empty.
         assign rdata  = empty ? '0 : mem[rd_ptr];
         assign rvalid = !empty;
      end else begin : g_std
         always_ff @(posedge clk) begin
            if (rst) begin
               rdata  <= '0;
               rvalid <= 1'b0;
            end else begin
               rvalid <= rd_acc;
               if (rd_acc) begin
                  rdata <= mem[rd_ptr];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Randomised and directed bench for sync_fifo_ext: standard depth-32, depth-5
// and FWFT instances, all checked against a queue-based model every cycle.
module tb_sync_fifo_ext;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [2:0]      wen_v = '0;
   logic [2:0]      ren_v = '0;
   logic [2:0][7:0] wdata_v = '0;
   logic [2:0]      full_v, afull_v, ovf_v, rvalid_v, empty_v, aempty_v, udf_v;
   logic [2:0][7:0] rdata_v;
   logic [5:0]      cnt_std, cnt_fw;
   logic [2:0]      cnt_d5;
   logic [7:0]      count_a [3];

   int n_checks = 0;
   int n_errors = 0;

   // Model configuration per instance: 0 = std depth 32, 1 = std depth 5, 2 = FWFT depth 32.
   int    depth_c  [3] = '{32, 5, 32};
   bit    fwft_c   [3] = '{1'b0, 1'b0, 1'b1};
   int    afull_c  [3] = '{28, 1, 28};
   int    aempty_c [3] = '{4, 4, 4};
   string nm       [3] = '{"std", "d5", "fwft"};

   logic [7:0] mq [3][$];
   logic [7:0] e_rd  [3];
   bit         e_rv  [3];
   bit         e_ovf [3];
   bit         e_udf [3];

   always #5 clk = ~clk;

   assign count_a[0] = {2'b00, cnt_std};
   assign count_a[1] = {5'b00000, cnt_d5};
   assign count_a[2] = {2'b00, cnt_fw};

   sync_fifo_ext u_std (
      .clk(clk), .rst(rst), .wen(wen_v[0]), .wdata(wdata_v[0]),
      .full(full_v[0]), .almost_full(afull_v[0]), .overflow(ovf_v[0]),
      .ren(ren_v[0]), .rdata(rdata_v[0]), .rvalid(rvalid_v[0]),
      .empty(empty_v[0]), .almost_empty(aempty_v[0]), .underflow(udf_v[0]),
      .count(cnt_std)
   );

   sync_fifo_ext #(.FIFO_DEPTH(5)) u_d5 (
      .clk(clk), .rst(rst), .wen(wen_v[1]), .wdata(wdata_v[1]),
      .full(full_v[1]), .almost_full(afull_v[1]), .overflow(ovf_v[1]),
      .ren(ren_v[1]), .rdata(rdata_v[1]), .rvalid(rvalid_v[1]),
      .empty(empty_v[1]), .almost_empty(aempty_v[1]), .underflow(udf_v[1]),
      .count(cnt_d5)
   );

   sync_fifo_ext #(.FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wen(wen_v[2]), .wdata(wdata_v[2]),
      .full(full_v[2]), .almost_full(afull_v[2]), .overflow(ovf_v[2]),
      .ren(ren_v[2]), .rdata(rdata_v[2]), .rvalid(rvalid_v[2]),
      .empty(empty_v[2]), .almost_empty(aempty_v[2]), .underflow(udf_v[2]),
      .count(cnt_fw)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Applies one clock edge of FIFO semantics to the queue model.
   task automatic model_edge(input int k);
      int         sz;
      bit         rd, wr;
      logic [7:0] d;
      sz = mq[k].size();
      if (rst) begin
         mq[k].delete();
         e_ovf[k] = 1'b0;
         e_udf[k] = 1'b0;
         e_rv[k]  = 1'b0;
         e_rd[k]  = 8'h00;
         return;
      end
      rd = ren_v[k] && (sz != 0);
      wr = wen_v[k] && ((sz != depth_c[k]) || rd);
      e_ovf[k] = wen_v[k] && !wr;
      e_udf[k] = ren_v[k] && !rd;
      e_rv[k]  = 1'b0;
      if (rd) begin
         d = mq[k].pop_front();
         if (!fwft_c[k]) begin
            e_rv[k] = 1'b1;
            e_rd[k] = d;
         end
      end
      if (wr) mq[k].push_back(wdata_v[k]);
   endtask

   task automatic check_outputs(input int k);
      int sz;
      sz = mq[k].size();
      check($sformatf("%s.count", nm[k]), 32'(count_a[k]), 32'(sz));
      check($sformatf("%s.empty", nm[k]), 32'(empty_v[k]), 32'(sz == 0));
      check($sformatf("%s.full", nm[k]), 32'(full_v[k]), 32'(sz == depth_c[k]));
      check($sformatf("%s.almost_full", nm[k]), 32'(afull_v[k]), 32'(sz >= afull_c[k]));
      check($sformatf("%s.almost_empty", nm[k]), 32'(aempty_v[k]), 32'(sz <= aempty_c[k]));
      check($sformatf("%s.overflow", nm[k]), 32'(ovf_v[k]), 32'(e_ovf[k]));
      check($sformatf("%s.underflow", nm[k]), 32'(udf_v[k]), 32'(e_udf[k]));
      if (fwft_c[k]) begin
         check($sformatf("%s.rvalid", nm[k]), 32'(rvalid_v[k]), 32'(sz != 0));
         check($sformatf("%s.rdata", nm[k]), 32'(rdata_v[k]), (sz != 0) ? 32'(mq[k][0]) : 32'd0);
      end else begin
         check($sformatf("%s.rvalid", nm[k]), 32'(rvalid_v[k]), 32'(e_rv[k]));
         check($sformatf("%s.rdata", nm[k]), 32'(rdata_v[k]), 32'(e_rd[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_edge(k);
      #1;
      for (int k = 0; k < 3; k++) check_outputs(k);
   endtask

   task automatic drive(input bit w, input bit r, input logic [7:0] d);
      for (int k = 0; k < 3; k++) begin
         wen_v[k]   = w;
         ren_v[k]   = r;
         wdata_v[k] = d;
      end
   endtask

   initial begin
      int wp;
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Three writes then three reads.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'(10 + i));
         step();
      end
      drive(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) step();
      drive(1'b0, 1'b0, 8'h00);
      step();
      step();

      // Fill past full, simultaneous ops at full, drain past empty.
      for (int i = 0; i < 33; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(100 + i));
         step();
      end
      drive(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 34; i++) step();
      drive(1'b1, 1'b1, 8'h77);
      step();
      drive(1'b0, 1'b1, 8'h00);
      step();
      drive(1'b0, 0, 8'h00);
      step();

      // Random traffic with shifting write bias, independent per instance.
      for (int ph = 0; ph < 4; ph++) begin
         wp = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 60 : 40;
         for (int c = 0; c < 150; c++) begin
            for (int k = 0; k < 3; k++) begin
               wen_v[k]   = ($urandom_range(0, 99) < wp);
               ren_v[k]   = ($urandom_range(0, 99) < (100 - wp));
               wdata_v[k] = 8'($urandom);
            end
            step();
         end
      end

      // Reset mid-operation with seven entries held.
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, 8'(8'h40 + i));
         step();
      end
      check("std.pre_rst_count", 32'(cnt_std), 32'd7);
      drive(1'b1, 1'b0, 8'hEE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("std.rst_count", 32'(cnt_std), 32'd0);
      check("std.rst_rvalid", 32'(rvalid_v[0]), 32'd0);
      drive(1'b1, 1'b0, 8'h3C);
      step();
      drive(1'b0, 1'b1, 8'h00);
      step();
      check("std.after_rst_rdata", 32'(rdata_v[0]), 32'h3C);
      drive(1'b0, 1'b0, 8'h00);
      step();

      // FWFT: head visible without ren, pop exposes the next word.
      drive(1'b1, 1'b0, 8'hA5);
      step();
      check("fwft.first_rdata", 32'(rdata_v[2]), 32'hA5);
      check("fwft.first_rvalid", 32'(rvalid_v[2]), 32'd1);
      drive(1'b1, 1'b0, 8'h5A);
      step();
      drive(1'b0, 1'b1, 8'h00);
      step();
      check("fwft.pop_rdata", 32'(rdata_v[2]), 32'h5A);
      check("fwft.pop_count", 32'(cnt_fw), 32'd1);
      drive(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) step();
      drive(1'b0, 1'b0, 8'h00);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
